memory_arbiter: RTL

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter_pkg.sv | 34 +++
 rtl/memory_arbiter_grant.sv | 62 ++++++
 rtl/memory_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared types and defaults for the two-requester memory arbiter.
package memory_arbiter_pkg;

   localparam int unsigned DEF_MEM_WORDS    = 8192;
   localparam int unsigned DEF_STARVE_LIMIT = 4;
   localparam int unsigned ADDR_W           = 32;
   localparam int unsigned DATA_W           = 32;

   // Depth of the tag pipeline: one stage for the registered RAM drive,
   // one stage for the RAM's registered read.
   localparam int unsigned TAG_STAGES       = 2;

   // Which requester a memory slot belongs to.
   typedef enum logic [1:0] {
      OWNER_NONE = 2'd0,
      OWNER_IF   = 2'd1,
      OWNER_D    = 2'd2
   } owner_e;

   // Per-transaction record that travels alongside the RAM access.
   typedef struct packed {
      owner_e owner;   // requester to route the response to
      logic   wr;      // write: respond with zero data (acknowledge only)
      logic   err;     // address outside the RAM: respond with error, zero data
   } tag_t;

   localparam tag_t TAG_IDLE = '{owner: OWNER_NONE, wr: 1'b0, err: 1'b0};

   // True when a word address lies beyond the populated RAM.
   function automatic logic addr_oob(input logic [ADDR_W-1:0] a, input int unsigned words);
      return (a >= words);
   endfunction

endpackage

// File: rtl/memory_arbiter_grant.sv
// Priority grant between instruction fetch and data requests.
// Data wins contention until fetch has watched STARVE_LIMIT data grants in a
// row while waiting; then fetch gets the next slot.
module memory_arbiter_grant
   import memory_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
)(
   input  logic   clk,
   input  logic   rst,
   input  logic   if_valid_i,
   input  logic   d_valid_i,
   output logic   if_grant_o,
   output logic   d_grant_o,
   output owner_e owner_o
);

   localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_q;
   logic [CNT_W-1:0] starve_d;
   logic             starved;

   // Grants are purely combinational from the valids and the counter; nothing
   // is granted while reset is asserted.
   always_comb begin
      starved    = (starve_q == LIMIT);
      if_grant_o = 1'b0;
      d_grant_o  = 1'b0;
      owner_o    = OWNER_NONE;
      if (!rst) begin
         if (if_valid_i && (!d_valid_i || starved)) begin
            if_grant_o = 1'b1;
            owner_o    = OWNER_IF;
         end else if (d_valid_i) begin
            d_grant_o  = 1'b1;
            owner_o    = OWNER_D;
         end
      end
   end

   // Count data grants that happen while fetch is waiting; saturate at the limit.
   always_comb begin
      starve_d = starve_q;
      if (!if_valid_i || if_grant_o) begin
         starve_d = '0;
      end else if (d_grant_o && !starved) begin
         starve_d = starve_q + 1'b1;
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port RAM with a
// registered read. One access per cycle, fixed two-edge response latency,
// responses returned in acceptance order.
module memory_arbiter
   import memory_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
   parameter int unsigned MEM_WORDS    = DEF_MEM_WORDS
)(
   input  logic              clk,
   input  logic              rst,
   // instruction fetch
   input  logic              if_req_valid,
   input  logic [ADDR_W-1:0] if_req_a,
   output logic              if_req_ready,
   output logic              if_rsp_valid,
   output logic [DATA_W-1:0] if_rsp_data,
   output logic              if_rsp_err,
   // data
   input  logic              d_req_valid,
   input  logic [ADDR_W-1:0] d_req_a,
   input  logic [DATA_W-1:0] d_req_din,
   input  logic              d_req_rw,
   output logic              d_req_ready,
   output logic              d_rsp_valid,
   output logic [DATA_W-1:0] d_rsp_data,
   output logic              d_rsp_err,
   // RAM
   output logic [ADDR_W-1:0] mem_a,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_rw,
   input  logic [DATA_W-1:0] mem_dout
);

   logic              if_grant;
   logic              d_grant;
   owner_e            grant_owner;

   logic [ADDR_W-1:0] req_a;
   logic              req_wr;
   logic              req_oob;
   tag_t              tag_d;
   tag_t              rsp_tag;
   logic              rsp_rd;

   logic [ADDR_W-1:0] mem_a_q;
   logic [ADDR_W-1:0] mem_a_d;
   logic [DATA_W-1:0] mem_din_q;
   logic [DATA_W-1:0] mem_din_d;
   logic              mem_rw_q;
   logic              mem_rw_d;

   memory_arbiter_grant #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_grant (
      .clk        (clk),
      .rst        (rst),
      .if_valid_i (if_req_valid),
      .d_valid_i  (d_req_valid),
      .if_grant_o (if_grant),
      .d_grant_o  (d_grant),
      .owner_o    (grant_owner)
   );

   assign if_req_ready = if_grant;
   assign d_req_ready  = d_grant;

   // Select the winning request, classify it and form the next RAM drive.
   // Out-of-range writes are demoted to no-ops so the RAM is never touched.
   always_comb begin
      req_a     = if_grant ? if_req_a : d_req_a;
      req_oob   = addr_oob(req_a, MEM_WORDS);
      req_wr    = d_grant && d_req_rw;
      tag_d     = TAG_IDLE;
      mem_a_d   = mem_a_q;
      mem_din_d = mem_din_q;
      mem_rw_d  = 1'b0;
      if (grant_owner != OWNER_NONE) begin
         tag_d    = '{owner: grant_owner, wr: req_wr, err: req_oob};
         mem_a_d  = req_a;
         mem_rw_d = req_wr && !req_oob;
         if (d_grant) begin
            mem_din_d = d_req_din;
         end
      end
   end

   // RAM drive registers; reset clears mem_rw so a pending write is cancelled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_a_q   <= '0;
         mem_din_q <= '0;
         mem_rw_q  <= 1'b0;
      end else begin
         mem_a_q   <= mem_a_d;
         mem_din_q <= mem_din_d;
         mem_rw_q  <= mem_rw_d;
      end
   end

   assign mem_a   = mem_a_q;
   assign mem_din = mem_din_q;
   assign mem_rw  = mem_rw_q;

   // Tag pipeline: stage 0 aligns with the registered RAM drive, the last
   // stage aligns with the RAM's registered read data.
   for (genvar gi = 0; gi < TAG_STAGES; gi++) begin : g_tag
      tag_t stage_d;
      tag_t stage_q;
      if (gi == 0) begin : g_head
         assign stage_d = tag_d;
      end else begin : g_tail
         assign stage_d = g_tag[gi-1].stage_q;
      end
      // Advance the tag one stage per edge; reset drops in-flight transactions.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            stage_q <= TAG_IDLE;
         end else begin
            stage_q <= stage_d;
         end
      end
   end

   assign rsp_tag = g_tag[TAG_STAGES-1].stage_q;

   // Route the response to its owner; the other port stays all-zero.
   always_comb begin
      rsp_rd       = (rsp_tag.owner != OWNER_NONE) && !rsp_tag.wr && !rsp_tag.err;
      if_rsp_valid = 1'b0;
      if_rsp_err   = 1'b0;
      if_rsp_data  = '0;
      d_rsp_valid  = 1'b0;
      d_rsp_err    = 1'b0;
      d_rsp_data   = '0;
      if (rsp_tag.owner == OWNER_IF) begin
         if_rsp_valid = 1'b1;
         if_rsp_err   = rsp_tag.err;
         if_rsp_data  = rsp_rd ? mem_dout : '0;
      end else if (rsp_tag.owner == OWNER_D) begin
         d_rsp_valid  = 1'b1;
         d_rsp_err    = rsp_tag.err;
         d_rsp_data   = rsp_rd ? mem_dout : '0;
      end
   end

endmodule
